// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg
// Shared definitions for the register-file write-port arbiter and its link FIFO.
//   REG_LINK   : architectural link register (R14) written by BL
//   STARVE_W   : width of the starvation counter (saturates at all-ones)
//   src_e      : which requester owns the write port in a given cycle
package writeback_arbiter_pkg;

  localparam logic [3:0] REG_LINK = 4'd14;
  localparam int         STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_LINK,
    SRC_MC
  } src_e;

endpackage

// File: rtl/writeback_arbiter_link_fifo.sv
// link_fifo
// Small circular FIFO holding BL return addresses waiting for the R14 write.
// Ports:
//   clk, rst         : rising-edge clock, asynchronous active-low reset
//   push_i, data_i   : enqueue data_i (ignored when full, unless flushing)
//   pop_i            : drop the head entry (ignored when empty)
//   flush_i          : discard every queued entry; a push in the same cycle
//                      lands in the freshly emptied queue
//   head_o           : oldest entry
//   count_o          : number of valid entries
//   empty_o, full_o  : occupancy flags
module link_fifo #(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] writeAddr;
  logic             doWrite;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  // Pointer/count update. A flush restarts both pointers at slot 0 so a
  // simultaneous push becomes the sole entry.
  always_comb begin
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    count_d   = count_q;
    writeAddr = wrPtr_q;
    doWrite   = 1'b0;
    if (flush_i) begin
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
      writeAddr = '0;
      if (push_i) begin
        doWrite = 1'b1;
        wrPtr_d = nextPtr('0);
        count_d = CNT_W'(1);
      end
    end else begin
      if (pop_i && !empty_o) begin
        rdPtr_d = nextPtr(rdPtr_q);
      end
      if (push_i && !full_o) begin
        doWrite = 1'b1;
        wrPtr_d = nextPtr(wrPtr_q);
      end
      count_d = count_q + CNT_W'(doWrite) - CNT_W'(pop_i && !empty_o);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem_q[writeAddr] <= data_i;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Sole owner of the register file's write port. Each cycle it grants at most
// one of: pipeline write-back, queued BL link write, multi-cycle unit result,
// and registers the winner onto writeBackEn/Dest_wb/Result_WB.
// Ports:
//   clk, rst                    : rising-edge clock, asynchronous active-low reset
//   wb_en/wb_dest/wb_value      : pipeline write-back (always granted)
//   link_req/link_pc            : BL retiring, queue link_pc for R14
//   link_ready                  : link queue can accept another entry
//   mc_valid/mc_dest/mc_value   : multi-cycle result, held until mc_ready
//   mc_ready                    : multi-cycle result accepted or discarded
//   writeBackEn/Dest_wb/Result_WB : registered register-file write
//   pending_mask                : registers with a write still waiting
//   stall_req                   : ask the pipeline for a bubble
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int LINK_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  input  logic        link_req,
  input  logic [31:0] link_pc,
  output logic        link_ready,
  input  logic        mc_valid,
  input  logic [3:0]  mc_dest,
  input  logic [31:0] mc_value,
  output logic        mc_ready,
  output logic        writeBackEn,
  output logic [3:0]  Dest_wb,
  output logic [31:0] Result_WB,
  output logic [15:0] pending_mask,
  output logic        stall_req
);

  localparam int CNT_W = $clog2(LINK_DEPTH + 1);

  logic [31:0]         fifoHead;
  logic [CNT_W-1:0]    fifoCount;
  logic                fifoEmpty;
  logic                fifoFull;
  logic                linkPush;
  logic                linkPop;
  logic                linkFlush;
  logic                mcDiscard;
  logic                waiting;
  src_e                src;

  logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;
  logic                wbEn_q, wbEn_d;
  logic [3:0]          dest_q, dest_d;
  logic [31:0]         result_q, result_d;

  link_fifo #(
    .DEPTH (LINK_DEPTH)
  ) u_link_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (linkPush),
    .pop_i   (linkPop),
    .flush_i (linkFlush),
    .data_i  (link_pc),
    .head_o  (fifoHead),
    .count_o (fifoCount),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull)
  );

  // Fixed-priority grant. The FIFO head is only eligible once it is already
  // registered, so a link pushed this cycle cannot be written this cycle.
  // Nothing is granted while reset is held.
  always_comb begin
    src = SRC_NONE;
    if (rst) begin
      if (wb_en) begin
        src = SRC_WB;
      end else if (!fifoEmpty) begin
        src = SRC_LINK;
      end else if (mc_valid) begin
        src = SRC_MC;
      end
    end
  end

  // A pipeline write to the same register is younger than the pending
  // multi-cycle result, so that result is acknowledged and dropped. Likewise
  // a pipeline write to R14 makes every queued link write stale.
  assign mcDiscard  = rst && mc_valid && wb_en && (mc_dest == wb_dest);
  assign mc_ready   = (src == SRC_MC) || mcDiscard;
  assign linkFlush  = (src == SRC_WB) && (wb_dest == REG_LINK);
  assign linkPop    = (src == SRC_LINK);
  assign link_ready = (fifoCount < CNT_W'(LINK_DEPTH));
  assign linkPush   = rst && link_req && !fifoFull;

  // Starvation counter: counts consecutive cycles in which the pipeline took
  // the port while a link or multi-cycle write was waiting.
  assign waiting = !fifoEmpty || mc_valid;

  always_comb begin
    starveCnt_d = '0;
    if ((src == SRC_WB) && waiting) begin
      starveCnt_d = (starveCnt_q == STARVE_MAX) ? STARVE_MAX : starveCnt_q + 1'b1;
    end
  end

  assign stall_req = (starveCnt_q >= STARVE_W'(STARVE_LIMIT)) || !link_ready;

  // Pending-destination mask for the hazard unit.
  always_comb begin
    pending_mask = '0;
    if (rst) begin
      pending_mask[REG_LINK] = !fifoEmpty;
      if (mc_valid) begin
        pending_mask[mc_dest] = 1'b1;
      end
    end
  end

  // Write-port mux. Address and data hold their last value when idle.
  always_comb begin
    wbEn_d   = (src != SRC_NONE);
    dest_d   = dest_q;
    result_d = result_q;
    case (src)
      SRC_WB: begin
        dest_d   = wb_dest;
        result_d = wb_value;
      end
      SRC_LINK: begin
        dest_d   = REG_LINK;
        result_d = fifoHead;
      end
      SRC_MC: begin
        dest_d   = mc_dest;
        result_d = mc_value;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveCnt_q <= '0;
      wbEn_q      <= 1'b0;
      dest_q      <= '0;
      result_q    <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      wbEn_q      <= wbEn_d;
      dest_q      <= dest_d;
      result_q    <= result_d;
    end
  end

  assign writeBackEn = wbEn_q;
  assign Dest_wb     = dest_q;
  assign Result_WB   = result_q;

endmodule
